// File: rtl/matrix_mem_pkg.sv
// matrix_mem_pkg: shared FSM states, fill-source codes and element addressing
package matrix_mem_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  localparam logic MODE_PATTERN = 1'b0;
  localparam logic MODE_STREAM = 1'b1;
  function automatic logic [15:0] elem_addr(input logic [7:0] row, input logic [7:0] col,
                                            input logic transpose, input logic [7:0] cols);
    return transpose ? 16'(col) * 16'(cols) + 16'(row) : 16'(row) * 16'(cols) + 16'(col);
  endfunction
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port, one registered read port
module sdp_ram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/matrix_mem_loader.sv
// matrix_mem_loader: self-filling operand matrix store with row-major/transposed reads
module matrix_mem_loader
  import matrix_mem_pkg::*;
#(
  parameter int DW = 32,
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int AW = 8,
  parameter int INIT_BASE = 10,
  parameter int INIT_STEP = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          rd_en,
  input  logic [7:0]    rd_row,
  input  logic [7:0]    rd_col,
  input  logic          rd_transpose,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_err,
  output logic          busy,
  output logic          wr_done
);
  localparam int N = ROWS * COLS;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  if (N > 2 ** AW) begin : gSizeCheck
    $error("matrix_mem_loader: ROWS*COLS exceeds 2**AW");
  end
  state_t state, stateNext;
  logic armed, modeQ, we, lastWr, rdOk, inRange, errHold, restart;
  logic [AW-1:0] idx;
  logic [15:0] rawAddr;
  logic [DW-1:0] patVal, wdata, ramQ;
  assign busy = armed && state == FILL;
  assign wr_done = state == DONE;
  assign s_ready = busy && modeQ == MODE_STREAM;
  assign we = busy && (modeQ == MODE_PATTERN || s_valid);
  assign lastWr = we && idx == LAST;
  assign restart = start && state != FILL;
  assign patVal = DW'(INIT_BASE) + DW'(INIT_STEP) * DW'(idx);
  assign wdata = modeQ == MODE_STREAM ? s_data : patVal;
  assign rawAddr = elem_addr(rd_row, rd_col, rd_transpose, 8'(COLS));
  assign inRange = rd_transpose ? (32'(rd_row) < COLS && 32'(rd_col) < ROWS)
                                : (32'(rd_row) < ROWS && 32'(rd_col) < COLS);
  assign rdOk = wr_done && inRange;
  assign rd_err = rd_valid && errHold;
  assign rd_data = errHold ? '0 : ramQ;
  always_comb begin
    stateNext = state == FILL ? (N == 0 ? IDLE : (lastWr ? DONE : FILL))
                              : (start ? FILL : state);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else state <= stateNext;
  end
  // errHold starts set so rd_data reads 0 before the first accepted read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
      modeQ <= MODE_PATTERN;
      idx <= '0;
      rd_valid <= 1'b0;
      errHold <= 1'b1;
    end else begin
      armed <= 1'b1;
      if (!armed || restart) modeQ <= mode;
      if (restart) idx <= '0;
      else if (we) idx <= lastWr ? '0 : idx + AW'(1);
      rd_valid <= rd_en;
      if (rd_en) errHold <= !rdOk;
    end
  end
  sdp_ram #(.DW(DW), .AW(AW)) uRam (
    .clk(clk),
    .we(we),
    .waddr(idx),
    .wdata(wdata),
    .re(rd_en && rdOk),
    .raddr(AW'(rawAddr)),
    .rdata(ramQ)
  );
endmodule
